// File: rtl/branch_dispatch.sv
// Branch dispatcher: accepts a pending-branch mask and hands off one index per
// handshake, lowest-numbered first, with abort and empty-mask error reporting.
module branch_dispatch #(
  parameter int IDX_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2**IDX_W-1:0]   in_mask,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [IDX_W-1:0]      out_index,
  output logic                  out_last,
  input  logic                  abort,
  output logic                  busy,
  output logic [IDX_W:0]        served_cnt,
  output logic                  empty_err
);

  localparam int MASK_W = 2**IDX_W;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [MASK_W-1:0]   pend_q, pend_d;
  logic [IDX_W:0]      served_cnt_q, served_cnt_d;
  logic                empty_err_q, empty_err_d;

  // Position of the lowest set bit; all-ones index when nothing is pending.
  function automatic logic [IDX_W-1:0] lowest_idx(input logic [MASK_W-1:0] v);
    lowest_idx = {IDX_W{1'b1}};
    for (int i = MASK_W - 1; i >= 0; i--) begin
      if (v[i]) begin
        lowest_idx = i[IDX_W-1:0];
      end
    end
  endfunction

  function automatic logic is_onehot(input logic [MASK_W-1:0] v);
    is_onehot = (v != {MASK_W{1'b0}}) &&
                ((v & (v - {{(MASK_W-1){1'b0}}, 1'b1})) == {MASK_W{1'b0}});
  endfunction

  // State, pending mask, served counter and error pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pend_q       <= {MASK_W{1'b0}};
      served_cnt_q <= {(IDX_W+1){1'b0}};
      empty_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      served_cnt_q <= served_cnt_d;
      empty_err_q  <= empty_err_d;
    end
  end

  // Outputs are decoded only from registered state.
  always_comb begin
    in_ready   = (state_q == IDLE);
    out_valid  = (state_q == EMIT);
    busy       = (state_q == EMIT);
    out_index  = lowest_idx(pend_q);
    out_last   = is_onehot(pend_q);
    served_cnt = served_cnt_q;
    empty_err  = empty_err_q;
  end

  // Next-state logic; abort wins over a simultaneous handshake.
  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    served_cnt_d = served_cnt_q;
    empty_err_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          served_cnt_d = {(IDX_W+1){1'b0}};
          if (in_mask != {MASK_W{1'b0}}) begin
            pend_d  = in_mask;
            state_d = EMIT;
          end else begin
            empty_err_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      EMIT: begin
        if (abort) begin
          pend_d  = {MASK_W{1'b0}};
          state_d = IDLE;
        end else if (out_ready) begin
          pend_d[out_index] = 1'b0;
          if (served_cnt_q != MASK_W[IDX_W:0]) begin
            served_cnt_d = served_cnt_q + {{IDX_W{1'b0}}, 1'b1};
          end else begin
            served_cnt_d = served_cnt_q;
          end
          if (out_last) begin
            state_d = IDLE;
          end else begin
            state_d = EMIT;
          end
        end else begin
          state_d = EMIT;
        end
      end
      default: begin
        state_d = IDLE;
        pend_d  = {MASK_W{1'b0}};
      end
    endcase
  end

endmodule

// File: doc/branch_dispatch.md
BRANCH_DISPATCH -- requirements
Module: branch_dispatch

Interface
REQ-001 The block SHALL have parameter IDX_W, default 4, meaning index width; the mask width is 2**IDX_W (16), and only the default is supported.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset; reset is synchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1: a new branch mask is offered.
REQ-005 The block SHALL have port in_ready, output, 1: the block can accept a mask.
REQ-006 The block SHALL have port in_mask, input, 16: pending-branch bit mask; bit i set means branch i pending.
REQ-007 The block SHALL have port out_valid, output, 1: out_index holds a pending branch.
REQ-008 The block SHALL have port out_ready, input, 1: the consumer accepts out_index.
REQ-009 The block SHALL have port out_index, output, 4: the lowest-numbered pending branch.
REQ-010 The block SHALL have port out_last, output, 1: out_index is the final pending branch of the current mask.
REQ-011 The block SHALL have port abort, input, 1: discard all pending branches.
REQ-012 The block SHALL have port busy, output, 1: a mask is being dispatched.
REQ-013 The block SHALL have port served_cnt, output, 5: the number of indices handed off for the current mask (0..16).
REQ-014 The block SHALL have port empty_err, output, 1: a one-cycle pulse when an all-zero mask is accepted.

Function
REQ-015 The block SHALL implement exactly two states, IDLE and EMIT, held in a registered state variable.
REQ-016 In IDLE, in_ready SHALL be 1 and out_valid SHALL be 0; in EMIT, in_ready SHALL be 0 and out_valid SHALL be 1.
REQ-017 Accept SHALL occur when in_valid and in_ready are both high; on accept of a nonzero mask, pend SHALL load in_mask, served_cnt SHALL clear to 0, and the state SHALL go to EMIT.
REQ-018 On accept of in_mask==0, the state SHALL stay IDLE, served_cnt SHALL clear to 0, and empty_err SHALL be 1 for exactly the next cycle.
REQ-019 Latency SHALL be one cycle: an accept at edge N gives out_valid=1 in the cycle after edge N.
REQ-020 out_index SHALL equal the position of the lowest set bit of pend; when pend==0 it SHALL be 4'hF.
REQ-021 out_last SHALL be 1 iff exactly one bit of pend is set.
REQ-022 A handshake SHALL occur when out_valid and out_ready are both high; it SHALL clear bit out_index of pend and increment served_cnt by 1.
REQ-023 A handshake with out_last=1 SHALL return the state to IDLE at the same edge.
REQ-024 While out_valid=1 and out_ready=0, out_index and out_last SHALL be held stable.
REQ-025 served_cnt SHALL hold its final value in IDLE until the next accept, and SHALL never exceed 16.
REQ-026 busy SHALL be 1 iff the state is EMIT.
REQ-027 When abort=1 in EMIT, pend SHALL clear to 0 and the state SHALL go to IDLE.
REQ-028 abort SHALL take priority over a simultaneous handshake: no bit is consumed, served_cnt holds, and the index counts as not delivered.
REQ-029 abort SHALL be ignored in IDLE, including in a cycle where an accept occurs.
REQ-030 A new mask SHALL NOT be accepted in the same cycle as the last handshake; the earliest next accept is in the following cycle (IDLE).

Reset
REQ-031 While rst=1 at a clock edge, the block SHALL set: state=IDLE, pend=0, served_cnt=0, empty_err=0.
REQ-032 After that reset edge, the outputs SHALL read: out_valid=0, in_ready=1, busy=0, out_index=4'hF, out_last=0.
REQ-033 Reset SHALL override every other input, including in the middle of EMIT; pending branches are lost.

Verification
REQ-034 Ordered drain: accept mask 16'h8421 with out_ready=1 held -> out_index sequence 0, 5, 10, 15 on consecutive cycles, out_last only on 15, then served_cnt=4 and the block is in IDLE.
REQ-035 Backpressure: accept mask 16'h0006 with out_ready low for 3 cycles -> out_index=1 stable for 3 cycles; then out_ready=1 -> 1 then 2, with out_last=1 on 2.
REQ-036 Empty mask: accept 16'h0000 -> empty_err=1 for one cycle, busy stays 0, served_cnt=0.
REQ-037 Abort collision: mask 16'hFFFF; after 2 handshakes, assert abort with out_ready=1 -> next cycle IDLE, served_cnt=2, out_index=4'hF.
REQ-038 Single and full masks: mask 16'h8000 -> one index 15 with out_last=1, served_cnt=1; mask 16'hFFFF -> indices 0..15, served_cnt=16.
REQ-039 Mid-run reset: mask 16'h00F0, assert rst after the first handshake -> next cycle all outputs at reset values and in_ready=1.
